// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, RV32I width
// codes and the width/alignment fault decode used at request acceptance.
package load_store_unit_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Unsigned widths exist only for loads; halfwords need even, words 4-aligned addresses.
   function automatic logic width_fault(input logic       wr_en,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
      logic bad;
      case (funct3)
         F3_B:    bad = 1'b0;
         F3_H:    bad = addr_lo[0];
         F3_W:    bad = (addr_lo != 2'b00);
         F3_BU:   bad = wr_en;
         F3_HU:   bad = wr_en | addr_lo[0];
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: load extraction/extension and SB/SH merge.
// Purely combinational, zero latency, no flow control.
module lsu_lane_align
   import load_store_unit_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  byte_off,
   input  logic [31:0] mem_word,
   input  logic [15:0] store_data,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      case (byte_off)
         2'd0:    lane_b = mem_word[7:0];
         2'd1:    lane_b = mem_word[15:8];
         2'd2:    lane_b = mem_word[23:16];
         default: lane_b = mem_word[31:24];
      endcase
      lane_h = byte_off[1] ? mem_word[31:16] : mem_word[15:0];

      case (funct3)
         F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
         F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
         F3_BU:   load_data = {24'h0, lane_b};
         F3_HU:   load_data = {16'h0, lane_h};
         default: load_data = mem_word;
      endcase

      // Only SB/SH reach the merge path, so funct3[0] alone picks byte vs halfword.
      merge_data = mem_word;
      if (funct3[1:0] == 2'b00) begin
         case (byte_off)
            2'd0:    merge_data[7:0]   = store_data[7:0];
            2'd1:    merge_data[15:8]  = store_data[7:0];
            2'd2:    merge_data[23:16] = store_data[7:0];
            default: merge_data[31:24] = store_data[7:0];
         endcase
      end else if (byte_off[1]) begin
         merge_data[31:16] = store_data;
      end else begin
         merge_data[15:0] = store_data;
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit against a 1-cycle word memory; done 1/2/3/4 cycles after accept
// (fault/SW/load/SB-SH). One access in flight: o_Ready low while busy, requests then dropped.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int MEM_WORDS = 1024
) (
   input  logic        i_Clk,
   input  logic        i_Rst,
   input  logic        i_Req,
   input  logic        i_WrEn,
   input  logic [2:0]  i_Funct3,
   input  logic [31:0] i_Addr,
   input  logic [31:0] i_WData,
   output logic        o_Ready,
   output logic        o_Done,
   output logic [31:0] o_RData,
   output logic        o_Fault,
   output logic        o_MemReadEn,
   output logic        o_MemWriteEn,
   output logic [31:0] o_MemAddrRead,
   output logic [31:0] o_MemAddrWrite,
   output logic [31:0] o_MemDataWrite,
   input  logic [31:0] i_MemAddrRead,
   input  logic [31:0] i_MemDataRead
);

   lsu_state_t  state;
   logic        wr_en_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   logic [15:0] wdata_q;
   logic        ready_q;
   logic        done_q;
   logic        fault_q;
   logic [31:0] rdata_q;
   logic        rd_en_q;
   logic        wr_en_mem_q;
   logic [31:0] rd_addr_q;
   logic [31:0] wr_addr_q;
   logic [31:0] wr_data_q;

   logic [31:0] req_idx;
   logic [31:0] word_idx;
   logic        req_fault;
   logic [31:0] load_data;
   logic [31:0] merge_data;

   assign req_idx   = {2'b00, i_Addr[31:2]};
   assign word_idx  = {2'b00, addr_q[31:2]};
   assign req_fault = width_fault(i_WrEn, i_Funct3, i_Addr[1:0]) || (req_idx >= 32'(MEM_WORDS));

   lsu_lane_align u_align (
      .funct3     (funct3_q),
      .byte_off   (addr_q[1:0]),
      .mem_word   (i_MemDataRead),
      .store_data (wdata_q),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

   // Reset gates the strobes immediately so an RMW cut short never writes.
   assign o_Ready        = ready_q & ~i_Rst;
   assign o_Done         = done_q;
   assign o_Fault        = fault_q;
   assign o_RData        = rdata_q;
   assign o_MemReadEn    = rd_en_q & ~i_Rst;
   assign o_MemWriteEn   = wr_en_mem_q & ~i_Rst;
   assign o_MemAddrRead  = i_Rst ? 32'h0 : rd_addr_q;
   assign o_MemAddrWrite = i_Rst ? 32'h0 : wr_addr_q;
   assign o_MemDataWrite = i_Rst ? 32'h0 : wr_data_q;

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state       <= ST_IDLE;
         wr_en_q     <= 1'b0;
         funct3_q    <= 3'b000;
         addr_q      <= 32'h0;
         wdata_q     <= 16'h0;
         ready_q     <= 1'b1;
         done_q      <= 1'b0;
         fault_q     <= 1'b0;
         rdata_q     <= 32'h0;
         rd_en_q     <= 1'b0;
         wr_en_mem_q <= 1'b0;
         rd_addr_q   <= 32'h0;
         wr_addr_q   <= 32'h0;
         wr_data_q   <= 32'h0;
      end else begin
         done_q      <= 1'b0;
         fault_q     <= 1'b0;
         rd_en_q     <= 1'b0;
         wr_en_mem_q <= 1'b0;
         rd_addr_q   <= 32'h0;
         wr_addr_q   <= 32'h0;
         wr_data_q   <= 32'h0;
         case (state)
            ST_IDLE: begin
               if (i_Req) begin
                  wr_en_q  <= i_WrEn;
                  funct3_q <= i_Funct3;
                  addr_q   <= i_Addr;
                  wdata_q  <= i_WData[15:0];
                  ready_q  <= 1'b0;
                  if (req_fault) begin
                     state   <= ST_DONE;
                     done_q  <= 1'b1;
                     fault_q <= 1'b1;
                     rdata_q <= 32'h0;
                  end else if (i_WrEn && (i_Funct3 == F3_W)) begin
                     state       <= ST_WRITE;
                     wr_en_mem_q <= 1'b1;
                     wr_addr_q   <= req_idx;
                     wr_data_q   <= i_WData;
                  end else begin
                     state     <= ST_READ;
                     rd_en_q   <= 1'b1;
                     rd_addr_q <= req_idx;
                  end
               end
            end
            ST_READ: state <= ST_WAIT;
            ST_WAIT: begin
               if (i_MemAddrRead != word_idx) begin
                  state   <= ST_DONE;
                  done_q  <= 1'b1;
                  fault_q <= 1'b1;
                  rdata_q <= 32'h0;
               end else if (!wr_en_q) begin
                  state   <= ST_DONE;
                  done_q  <= 1'b1;
                  rdata_q <= load_data;
               end else begin
                  state       <= ST_WRITE;
                  wr_en_mem_q <= 1'b1;
                  wr_addr_q   <= word_idx;
                  wr_data_q   <= merge_data;
               end
            end
            ST_WRITE: begin
               state   <= ST_DONE;
               done_q  <= 1'b1;
               rdata_q <= 32'h0;
            end
            ST_DONE: begin
               state   <= ST_IDLE;
               ready_q <= 1'b1;
            end
            default: begin
               state   <= ST_IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: memory responder, per-cycle schedule model, directed and random traffic.
module tb_load_store_unit;

   localparam int MW = 1024;

   logic        i_Clk = 1'b0;
   logic        i_Rst = 1'b1;
   logic        i_Req = 1'b0;
   logic        i_WrEn = 1'b0;
   logic [2:0]  i_Funct3 = 3'b000;
   logic [31:0] i_Addr = 32'h0;
   logic [31:0] i_WData = 32'h0;
   logic [31:0] i_MemAddrRead = 32'h0;
   logic [31:0] i_MemDataRead = 32'h0;
   logic        o_Ready, o_Done, o_Fault, o_MemReadEn, o_MemWriteEn;
   logic [31:0] o_RData, o_MemAddrRead, o_MemAddrWrite, o_MemDataWrite;

   load_store_unit #(.MEM_WORDS(MW)) dut (
      .i_Clk          (i_Clk),
      .i_Rst          (i_Rst),
      .i_Req          (i_Req),
      .i_WrEn         (i_WrEn),
      .i_Funct3       (i_Funct3),
      .i_Addr         (i_Addr),
      .i_WData        (i_WData),
      .o_Ready        (o_Ready),
      .o_Done         (o_Done),
      .o_RData        (o_RData),
      .o_Fault        (o_Fault),
      .o_MemReadEn    (o_MemReadEn),
      .o_MemWriteEn   (o_MemWriteEn),
      .o_MemAddrRead  (o_MemAddrRead),
      .o_MemAddrWrite (o_MemAddrWrite),
      .o_MemDataWrite (o_MemDataWrite),
      .i_MemAddrRead  (i_MemAddrRead),
      .i_MemDataRead  (i_MemDataRead)
   );

   initial forever #5 i_Clk = ~i_Clk;

   logic [31:0] dmem    [0:MW-1];
   logic [31:0] ref_mem [0:MW-1];
   int          vectors = 0;
   int          errors  = 0;
   int          rd_cnt  = 0;
   int          wr_cnt  = 0;
   logic [31:0] last_rd_idx = 32'h0;
   bit          echo_bad_now = 1'b0;
   bit          resp_corrupt = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Memory: address and data echo one cycle after the read strobe.
   always @(posedge i_Clk) begin
      if (o_MemWriteEn) begin
         wr_cnt++;
         if (o_MemAddrWrite < MW) dmem[o_MemAddrWrite[9:0]] <= o_MemDataWrite;
      end
      if (o_MemReadEn) begin
         rd_cnt++;
         last_rd_idx   <= o_MemAddrRead;
         i_MemAddrRead <= resp_corrupt ? (o_MemAddrRead ^ 32'h1) : o_MemAddrRead;
         i_MemDataRead <= (o_MemAddrRead < MW) ? dmem[o_MemAddrRead[9:0]] : 32'h0;
      end else begin
         i_MemAddrRead <= $urandom;
         i_MemDataRead <= $urandom;
      end
   end

   // Reference model: each accepted access becomes a schedule of strobe/done cycles.
   int          cyc = 0;
   int          t_done = -1;
   int          t_rd = -1;
   int          t_wr = -1;
   bit          prev_rst = 1'b1;
   bit          m_fault = 1'b0;
   logic [31:0] m_idx = 32'h0;
   logic [31:0] m_wword = 32'h0;
   logic [31:0] m_rdata = 32'h0;
   logic [31:0] held = 32'h0;

   always @(negedge i_Clk) begin : model
      bit          e_done, e_rd, e_wr, e_ready, illegal, misal, oor;
      logic [31:0] idx, old, v, mask;
      int          sh;
      cyc++;
      if (prev_rst) begin
         t_done = -1; t_rd = -1; t_wr = -1; held = 32'h0;
      end
      e_done  = (cyc == t_done);
      if (e_done) held = m_rdata;
      e_rd    = (cyc == t_rd) && !i_Rst;
      e_wr    = (cyc == t_wr) && !i_Rst;
      e_ready = (t_done < cyc) && !i_Rst;
      check("o_Ready", {31'h0, o_Ready}, {31'h0, e_ready});
      check("o_Done", {31'h0, o_Done}, {31'h0, e_done});
      check("o_Fault", {31'h0, o_Fault}, {31'h0, e_done && m_fault});
      check("o_RData", o_RData, held);
      check("o_MemReadEn", {31'h0, o_MemReadEn}, {31'h0, e_rd});
      check("o_MemWriteEn", {31'h0, o_MemWriteEn}, {31'h0, e_wr});
      check("o_MemAddrRead", o_MemAddrRead, e_rd ? m_idx : 32'h0);
      check("o_MemAddrWrite", o_MemAddrWrite, e_wr ? m_idx : 32'h0);
      check("o_MemDataWrite", o_MemDataWrite, e_wr ? m_wword : 32'h0);
      if (e_wr) ref_mem[m_idx[9:0]] = m_wword;

      if (e_ready && i_Req === 1'b1) begin
         idx     = i_Addr >> 2;
         sh      = 8 * int'(i_Addr[1:0]);
         illegal = (i_Funct3 == 3) || (i_Funct3 == 6) || (i_Funct3 == 7) || (i_WrEn && i_Funct3[2]);
         misal   = ((i_Funct3 == 1 || i_Funct3 == 5) && i_Addr[0]) ||
                   (i_Funct3 == 2 && i_Addr[1:0] != 2'b00);
         oor     = (idx >= MW);
         old     = oor ? 32'h0 : ref_mem[idx[9:0]];
         m_idx   = idx;
         m_fault = 1'b0;
         m_rdata = 32'h0;
         if (illegal || misal || oor) begin
            m_fault = 1'b1;
            t_done  = cyc + 1;
         end else if (i_WrEn && i_Funct3 == 2) begin
            m_wword = i_WData;
            t_wr    = cyc + 1;
            t_done  = cyc + 2;
         end else begin
            t_rd         = cyc + 1;
            resp_corrupt = echo_bad_now;
            if (echo_bad_now) begin
               m_fault = 1'b1;
               t_done  = cyc + 3;
            end else if (!i_WrEn) begin
               v = old >> sh;
               case (i_Funct3)
                  3'd0:    m_rdata = {{24{v[7]}}, v[7:0]};
                  3'd1:    m_rdata = {{16{v[15]}}, v[15:0]};
                  3'd4:    m_rdata = {24'h0, v[7:0]};
                  3'd5:    m_rdata = {16'h0, v[15:0]};
                  default: m_rdata = old;
               endcase
               t_done = cyc + 3;
            end else begin
               mask    = ((i_Funct3 == 0) ? 32'hFF : 32'hFFFF) << sh;
               m_wword = (old & ~mask) | ((i_WData << sh) & mask);
               t_wr    = cyc + 3;
               t_done  = cyc + 4;
            end
         end
      end
      prev_rst = i_Rst;
   end

   task automatic preload(input int w, input logic [31:0] val);
      dmem[w]    = val;
      ref_mem[w] = val;
   endtask

   // Entered and left at posedge+1; literal latency/data/fault expectations.
   task automatic access(input string nm, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int exp_lat, input logic [31:0] exp_rd,
                         input bit exp_flt);
      int n, lat, rd0, wr0;
      n = 0;
      while (!o_Ready && n < 20) begin
         @(posedge i_Clk); #1;
         n++;
      end
      check({nm, " ready"}, {31'h0, o_Ready}, 32'h1);
      i_Req = 1'b1; i_WrEn = wr; i_Funct3 = f3; i_Addr = addr; i_WData = wd;
      rd0 = rd_cnt; wr0 = wr_cnt;
      @(posedge i_Clk); #1;
      i_Req = 1'b0;
      lat = 1;
      while (!o_Done && lat < 10) begin
         @(posedge i_Clk); #1;
         lat++;
      end
      check({nm, " latency"}, 32'(lat), 32'(exp_lat));
      check({nm, " rdata"}, o_RData, exp_rd);
      check({nm, " fault"}, {31'h0, o_Fault}, {31'h0, exp_flt});
      if (exp_flt) begin
         check({nm, " read strobes"}, 32'(rd_cnt - rd0), 32'h0);
         check({nm, " write strobes"}, 32'(wr_cnt - wr0), 32'h0);
      end
   endtask

   logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
   logic [2:0] st_f3 [3] = '{3'b000, 3'b001, 3'b010};

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1);
   end

   initial begin : main
      int wr0, ndone;
      int done_at [$];
      for (int i = 0; i < MW; i++) preload(i, $urandom);

      repeat (3) @(posedge i_Clk);
      #1;
      check("reset o_Ready", {31'h0, o_Ready}, 32'h0);
      check("reset o_Done", {31'h0, o_Done}, 32'h0);
      check("reset o_RData", o_RData, 32'h0);
      i_Rst = 1'b0;
      #1;
      check("ready after reset", {31'h0, o_Ready}, 32'h1);

      preload(4, 32'hDEADBEEF);
      access("LW 0x10", 1'b0, 3'b010, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0);
      check("LW read index", last_rd_idx, 32'd4);

      preload(4, 32'h80FF7F01);
      access("LB 0x13", 1'b0, 3'b000, 32'h13, 32'h0, 3, 32'hFFFFFF80, 1'b0);
      access("LBU 0x13", 1'b0, 3'b100, 32'h13, 32'h0, 3, 32'h00000080, 1'b0);
      access("LH 0x12", 1'b0, 3'b001, 32'h12, 32'h0, 3, 32'hFFFF80FF, 1'b0);
      access("LHU 0x10", 1'b0, 3'b101, 32'h10, 32'h0, 3, 32'h00007F01, 1'b0);

      preload(4, 32'h11223344);
      access("SB 0x12", 1'b1, 3'b000, 32'h12, 32'h000000AB, 4, 32'h0, 1'b0);
      check("mem after SB", dmem[4], 32'h11AB3344);
      access("SH 0x10", 1'b1, 3'b001, 32'h10, 32'h0000CAFE, 4, 32'h0, 1'b0);
      check("mem after SH", dmem[4], 32'h11ABCAFE);
      access("SW 0x18", 1'b1, 3'b010, 32'h18, 32'h01234567, 2, 32'h0, 1'b0);
      check("mem after SW", dmem[6], 32'h01234567);

      access("LW 0x11", 1'b0, 3'b010, 32'h11, 32'h0, 1, 32'h0, 1'b1);
      access("SH 0x13", 1'b1, 3'b001, 32'h13, 32'h0, 1, 32'h0, 1'b1);
      access("funct3 011", 1'b0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1'b1);
      access("LW 0x1000", 1'b0, 3'b010, 32'h1000, 32'h0, 1, 32'h0, 1'b1);
      access("SBU store", 1'b1, 3'b100, 32'h10, 32'h0, 1, 32'h0, 1'b1);

      // Reset lands during the WAIT cycle of an SB: no write may escape.
      preload(5, 32'h55667788);
      wr0 = wr_cnt;
      i_Req = 1'b1; i_WrEn = 1'b1; i_Funct3 = 3'b000; i_Addr = 32'h15; i_WData = 32'h99;
      @(posedge i_Clk); #1;
      i_Req = 1'b0;
      @(posedge i_Clk); #1;
      i_Rst = 1'b1;
      @(posedge i_Clk); #1;
      i_Rst = 1'b0;
      #1;
      check("abort ready", {31'h0, o_Ready}, 32'h1);
      check("abort write strobes", 32'(wr_cnt - wr0), 32'h0);
      check("abort mem", dmem[5], 32'h55667788);
      access("LW after abort", 1'b0, 3'b010, 32'h14, 32'h0, 3, 32'h55667788, 1'b0);

      // Request held high: SW must complete every 3 cycles, one per IDLE visit.
      @(posedge i_Clk); #1;
      wr0 = wr_cnt;
      i_Req = 1'b1; i_WrEn = 1'b1; i_Funct3 = 3'b010; i_Addr = 32'h20; i_WData = $urandom;
      for (int k = 1; k <= 12; k++) begin
         @(posedge i_Clk); #1;
         i_WData = $urandom;
         if (o_Done) done_at.push_back(k);
      end
      i_Req = 1'b0;
      ndone = done_at.size();
      check("held-req done count", 32'(ndone), 32'd4);
      check("held-req write count", 32'(wr_cnt - wr0), 32'd4);
      for (int j = 1; j < ndone; j++)
         check("held-req spacing", 32'(done_at[j] - done_at[j-1]), 32'd3);

      for (int n = 0; n < 2500; n++) begin
         @(posedge i_Clk); #1;
         i_Rst  = ($urandom_range(0, 99) == 0);
         i_Req  = 1'($urandom_range(0, 1));
         i_WrEn = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) != 0)
            i_Funct3 = i_WrEn ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
         else
            i_Funct3 = 3'($urandom_range(0, 7));
         i_Addr  = ($urandom_range(0, 24) == 0) ? $urandom : 32'($urandom_range(0, 63));
         i_WData = $urandom;
         echo_bad_now = ($urandom_range(0, 15) == 0);
      end
      i_Req = 1'b0; i_Rst = 1'b0; echo_bad_now = 1'b0;
      repeat (8) @(posedge i_Clk);
      #1;
      for (int i = 0; i < 16; i++) check($sformatf("mem[%0d]", i), dmem[i], ref_mem[i]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
